mio_bus_ctrl: RTL and testbench

//   Memory/IO bus controller directly downstream of the multi-cycle CPU's MIO port.

---
 rtl/mio_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the CPU MIO port: RAM with wait states, GPIO, free-running counter.
// Optional define MIO_TIMER_IRQ_EN adds a compare register at 0xF000_0004 driving timer_irq_o.
//   state | meaning
//   IDLE  | waiting for cpu_req_i; latches and decodes the access
//   WAIT  | RAM access in flight, down-counter runs to 0
//   RESP  | cpu_ready_o pulse, cpu_rdata_o valid
module mio_bus_ctrl #(
    parameter int RAM_WAIT = 2,
    parameter int RAM_AW   = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic [31:0]       gpio_in_i,
    output logic [31:0]       gpio_out_o,
    output logic              bus_err_o,
    output logic              timer_irq_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] TGT_RAM  = 3'd0;
    localparam logic [2:0] TGT_GPIO = 3'd1;
    localparam logic [2:0] TGT_CNT  = 3'd2;
    localparam logic [2:0] TGT_ERR  = 3'd4;
`ifdef MIO_TIMER_IRQ_EN
    localparam logic [2:0] TGT_CMP  = 3'd3;
`endif

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [RAM_AW-1:0] raddr_q, raddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       gpio_q, gpio_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [2:0]        tgt;
`ifdef MIO_TIMER_IRQ_EN
    logic [31:0]       cmp_q, cmp_d;
    logic              irq_q, irq_d;
`endif

    always_comb begin
        tgt = TGT_ERR;
        if (cpu_addr_i[1:0] == 2'b00) begin
            case (cpu_addr_i[31:28])
                4'h0: tgt = TGT_RAM;
                4'hE: tgt = TGT_GPIO;
                4'hF: begin
                    if (cpu_addr_i[27:0] == 28'h0) tgt = TGT_CNT;
`ifdef MIO_TIMER_IRQ_EN
                    else if (cpu_addr_i[27:0] == 28'h4) tgt = TGT_CMP;
`endif
                end
                default: tgt = TGT_ERR;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        raddr_d  = raddr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ram_we_d = 1'b0;
        gpio_d   = gpio_q;
        cnt_d    = cnt_q + 32'd1;
        err_d    = err_q;
`ifdef MIO_TIMER_IRQ_EN
        cmp_d    = cmp_q;
        irq_d    = irq_q | (cnt_q == cmp_q);
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    raddr_d = cpu_addr_i[RAM_AW+1:2];
                    wdata_d = cpu_wdata_i;
                    if (tgt == TGT_RAM) begin
                        state_d  = ST_WAIT;
                        wcnt_d   = WAIT_INIT;
                        ram_we_d = cpu_we_i;
                    end else begin
                        // Peripheral writes land on the edge entering RESP, so they are visible with the ready pulse.
                        state_d = ST_RESP;
                        rdata_d = 32'h0;
                        case (tgt)
                            TGT_GPIO: if (cpu_we_i) gpio_d = cpu_wdata_i; else rdata_d = gpio_in_i;
                            TGT_CNT:  if (cpu_we_i) cnt_d = cpu_wdata_i; else rdata_d = cnt_q;
`ifdef MIO_TIMER_IRQ_EN
                            TGT_CMP: begin
                                if (cpu_we_i) begin
                                    cmp_d = cpu_wdata_i;
                                    irq_d = 1'b0;
                                end else begin
                                    rdata_d = cmp_q;
                                end
                            end
`endif
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    rdata_d = ram_rdata_i;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            raddr_q  <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            ram_we_q <= 1'b0;
            gpio_q   <= 32'h0;
            cnt_q    <= 32'h0;
            err_q    <= 1'b0;
`ifdef MIO_TIMER_IRQ_EN
            cmp_q    <= 32'hFFFF_FFFF;
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ram_we_q <= ram_we_d;
            gpio_q   <= gpio_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef MIO_TIMER_IRQ_EN
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
`endif
        end
    end

    // Drive the RAM from the live CPU address while idle so read data is ready even with zero wait states.
    assign ram_addr_o  = (state_q == ST_IDLE) ? cpu_addr_i[RAM_AW+1:2] : raddr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_wdata_o = wdata_q;
    assign cpu_ready_o = (state_q == ST_RESP);
    assign cpu_rdata_o = rdata_q;
    assign gpio_out_o  = gpio_q;
    assign bus_err_o   = err_q;
`ifdef MIO_TIMER_IRQ_EN
    assign timer_irq_o = irq_q;
`else
    assign timer_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed scenarios plus random accesses against a transaction-level model.
module tb_mio_bus_ctrl;
    localparam int RAM_WAIT = 2;
    localparam int RAM_AW   = 10;
`ifdef MIO_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic cpu_req, cpu_we, cpu_ready, ram_we, bus_err, timer_irq;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata, gpio_in, gpio_out;
    logic [RAM_AW-1:0] ram_addr;

    mio_bus_ctrl #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
        .clk_i(clk), .reset_i(reset), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .cpu_ready_o(cpu_ready), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .gpio_in_i(gpio_in),
        .gpio_out_o(gpio_out), .bus_err_o(bus_err), .timer_irq_o(timer_irq)
    );

    always #5 clk = ~clk;

    // Synchronous RAM attached to the controller
    logic [31:0] ram_mem [2**RAM_AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_cnt = 0;
    int rdy_cnt = 0;
    logic [RAM_AW-1:0] we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_addr = ram_addr;
            we_data = ram_wdata;
        end
        if (cpu_ready) rdy_cnt++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] exp_mem [2**RAM_AW];
    logic [31:0] cnt_base;
    int          cnt_cyc;
    logic [31:0] gpio_m;
    logic [31:0] cmp_m;
    logic        err_m;

    localparam int R_RAM = 0, R_GPIO = 1, R_CNT = 2, R_CMP = 3, R_ERR = 4;

    function automatic int region(input logic [31:0] a);
        if (a[1:0] != 2'b00) return R_ERR;
        if (a[31:28] == 4'h0) return R_RAM;
        if (a[31:28] == 4'hE) return R_GPIO;
        if (a == 32'hF000_0000) return R_CNT;
        if (a == 32'hF000_0004 && IRQ_EN) return R_CMP;
        return R_ERR;
    endfunction

    function automatic logic [31:0] cnt_at(input int c);
        return cnt_base + 32'(c - cnt_cyc);
    endfunction

    task automatic model_reset();
        cnt_base = 32'h0;
        cnt_cyc  = cyc;
        gpio_m   = 32'h0;
        cmp_m    = 32'hFFFF_FFFF;
        err_m    = 1'b0;
    endtask

    // One complete CPU access, started at a negedge while the controller is idle.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] gin, input string tag, output logic [31:0] rd);
        int r;
        int lat;
        int w0;
        int cn;
        logic [31:0] exp_rd;
        r  = region(addr);
        w0 = we_cnt;
        cn = cyc;
        gpio_in = gin;
        case (r)
            R_RAM:   exp_rd = exp_mem[addr[RAM_AW+1:2]];
            R_GPIO:  exp_rd = gin;
            R_CNT:   exp_rd = cnt_at(cn);
            R_CMP:   exp_rd = cmp_m;
            default: exp_rd = 32'h0;
        endcase
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ready && lat < 40);
        rd = cpu_rdata;
        chk({tag, "_latency"}, 32'(lat), (r == R_RAM) ? 32'(2 + RAM_WAIT) : 32'd1);
        if (!we) chk({tag, "_rdata"}, rd, exp_rd);
        if (we && r == R_GPIO) chk({tag, "_gpio_at_ready"}, gpio_out, wdata);
        cpu_req = 1'b0;
        if (we) begin
            case (r)
                R_RAM:  exp_mem[addr[RAM_AW+1:2]] = wdata;
                R_GPIO: gpio_m = wdata;
                R_CNT:  begin cnt_base = wdata; cnt_cyc = cn + 1; end
                R_CMP:  cmp_m = wdata;
                default: ;
            endcase
        end
        if (r == R_ERR) err_m = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_pulse"}, {31'h0, cpu_ready}, 32'h0);
        chk({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, err_m});
        chk({tag, "_gpio_out"}, gpio_out, gpio_m);
        chk({tag, "_ram_we_count"}, 32'(we_cnt - w0), (we && r == R_RAM) ? 32'd1 : 32'd0);
        if (we && r == R_RAM) begin
            chk({tag, "_ram_waddr"}, 32'(we_addr), 32'(addr[RAM_AW+1:2]));
            chk({tag, "_ram_wdata"}, we_data, wdata);
        end
        if (!we) chk({tag, "_rdata_hold"}, cpu_rdata, exp_rd);
    endtask

    logic [31:0] rd;
    logic [31:0] a, wd;
    int n;

    initial begin
        for (int i = 0; i < 2**RAM_AW; i++) begin
            ram_mem[i] <= 32'h0;
            exp_mem[i] = 32'h0;
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; gpio_in = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // RAM write then read back
        xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, "t1_wr", rd);
        xfer(1'b0, 32'h0000_0010, 32'h0, 32'h0, "t1_rd", rd);
        chk("t1_readback", rd, 32'h1234_5678);

        // GPIO
        xfer(1'b1, 32'hE000_0000, 32'hA5A5_0000, 32'h0, "t2_wr", rd);
        xfer(1'b0, 32'hE000_0000, 32'h0, 32'h0000_00FF, "t2_rd", rd);

        // Counter wrap: FFFF_FFFE, FFFF_FFFF, 0, 1 at the read's accept cycle
        xfer(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'h0, "t3_wr", rd);
        repeat (2) @(negedge clk);
        xfer(1'b0, 32'hF000_0000, 32'h0, 32'h0, "t3_rd", rd);
        chk("t3_wrapped_value", rd, 32'h0000_0001);

        // Error accesses
        xfer(1'b0, 32'h5000_0000, 32'h0, 32'h0, "t4_unmapped", rd);
        xfer(1'b1, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0, "t4_misaligned", rd);
        repeat (3) @(negedge clk);
        chk("t4_bus_err_sticky", {31'h0, bus_err}, 32'h1);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: a = {22'h0, 6'($urandom_range(0, 15)), 4'h0} >> 2 << 2;
                1: a = 32'hE000_0000 | ($urandom & 32'h0FFF_FFFC);
                2: a = 32'hF000_0000;
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                        1: a = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFF);
                        default: a = 32'hF000_0008;
                    endcase
                end
            endcase
            wd = $urandom;
            xfer(1'($urandom_range(0, 1)), a, wd, $urandom, "rnd", rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a RAM write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        n = rdy_cnt;
        reset = 1'b1;
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_gpio_cleared", gpio_out, 32'h0);
        chk("t5_bus_err_cleared", {31'h0, bus_err}, 32'h0);
        chk("t5_rdata_cleared", cpu_rdata, 32'h0);
        chk("t5_ram_we_low", {31'h0, ram_we}, 32'h0);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("t5_no_ready_pulse", 32'(rdy_cnt - n), 32'h0);
        xfer(1'b0, 32'h0000_0100, 32'h0, 32'h0, "t5_after_rd", rd);
        xfer(1'b1, 32'h0000_0104, 32'h0BAD_CAFE, 32'h0, "t5_after_wr", rd);
        xfer(1'b0, 32'hF000_0000, 32'h0, 32'h0, "t5_cnt_rd", rd);

`ifdef MIO_TIMER_IRQ_EN
        xfer(1'b1, 32'hF000_0000, 32'd1000, 32'h0, "t6_cnt_park", rd);
        xfer(1'b1, 32'hF000_0004, 32'd20, 32'h0, "t6_cmp_wr", rd);
        chk("t6_irq_low", {31'h0, timer_irq}, 32'h0);
        xfer(1'b1, 32'hF000_0000, 32'd10, 32'h0, "t6_cnt_wr", rd);
        n = 0;
        while (!timer_irq && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_irq_set", {31'h0, timer_irq}, 32'h1);
        chk("t6_irq_timing", 32'(cyc - cnt_cyc), 32'd11);
        xfer(1'b0, 32'hF000_0004, 32'h0, 32'h0, "t6_cmp_rd", rd);
        chk("t6_irq_held", {31'h0, timer_irq}, 32'h1);
        xfer(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 32'h0, "t6_cmp_clr", rd);
        chk("t6_irq_cleared", {31'h0, timer_irq}, 32'h0);
`else
        xfer(1'b0, 32'hF000_0004, 32'h0, 32'h0, "t6_cmp_unmapped", rd);
        xfer(1'b1, 32'hF000_0004, 32'd20, 32'h0, "t6_cmp_unmapped_wr", rd);
        repeat (30) @(negedge clk);
        chk("t6_irq_tied_low", {31'h0, timer_irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
